// File: rtl/dct_t2.sv
// dct_t2: 4-point orthonormal DCT-II, four signed 16-bit samples in, four coefficients out.
// Latency: 2 clocks (butterfly register, then multiply/round register); throughput 1 vector/clock.
// Backpressure: none; free-running, a new vector is accepted on every rising edge.
// Optional: define DCT_SATURATE_EN to clamp results to 16-bit range instead of wrapping.
module dct_t2 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample0,
  input  logic [15:0] sample1,
  input  logic [15:0] sample2,
  input  logic [15:0] sample3,
  output logic [15:0] out_sample0,
  output logic [15:0] out_sample1,
  output logic [15:0] out_sample2,
  output logic [15:0] out_sample3
);

  // Q15 cosine constants
  localparam logic signed [35:0] COEF_A = 36'sd21407;  // 0.6532815
  localparam logic signed [35:0] COEF_B = 36'sd8867;   // 0.2705981
  localparam logic signed [35:0] COEF_H = 36'sd16384;  // 0.5
  localparam logic signed [35:0] RND    = 36'sd16384;  // half LSB after >>15

  logic signed [15:0] x0, x1, x2, x3;
  logic signed [16:0] s03, d03, s12, d12;
  logic signed [35:0] e_s03, e_d03, e_s12, e_d12;
  logic signed [35:0] acc0, acc1, acc2, acc3;

  assign x0 = sample0;
  assign x1 = sample1;
  assign x2 = sample2;
  assign x3 = sample3;

`ifdef DCT_SATURATE_EN
  // Round (half toward +inf) and clamp into the signed 16-bit range.
  function automatic logic [15:0] fin16(input logic signed [35:0] acc);
    logic signed [35:0] r;
    r = (acc + RND) >>> 15;
    if (r > 36'sd32767)
      fin16 = 16'h7FFF;
    else if (r < -36'sd32768)
      fin16 = 16'h8000;
    else
      fin16 = 16'(r);
  endfunction
`else
  // Round (half toward +inf) and keep the low 16 bits (two's complement wrap).
  function automatic logic [15:0] fin16(input logic signed [35:0] acc);
    fin16 = 16'((acc + RND) >>> 15);
  endfunction
`endif

  // Stage 1: 17-bit butterflies, full precision so no overflow is possible.
  always_ff @(posedge clk) begin
    if (reset) begin
      s03 <= '0;
      d03 <= '0;
      s12 <= '0;
      d12 <= '0;
    end else begin
      s03 <= 17'(x0) + 17'(x3);
      d03 <= 17'(x0) - 17'(x3);
      s12 <= 17'(x1) + 17'(x2);
      d12 <= 17'(x1) - 17'(x2);
    end
  end

  // Sign-extend butterflies to the 36-bit accumulator width.
  assign e_s03 = 36'(s03);
  assign e_d03 = 36'(d03);
  assign e_s12 = 36'(s12);
  assign e_d12 = 36'(d12);

  // Full-precision products; worst case magnitude fits in 34 bits signed.
  always_comb begin
    acc0 = (e_s03 + e_s12) * COEF_H;
    acc1 = (e_d03 * COEF_A) + (e_d12 * COEF_B);
    acc2 = (e_s03 - e_s12) * COEF_H;
    acc3 = (e_d03 * COEF_B) - (e_d12 * COEF_A);
  end

  // Stage 2: round, range-limit and register the coefficients.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_sample0 <= '0;
      out_sample1 <= '0;
      out_sample2 <= '0;
      out_sample3 <= '0;
    end else begin
      out_sample0 <= fin16(acc0);
      out_sample1 <= fin16(acc1);
      out_sample2 <= fin16(acc2);
      out_sample3 <= fin16(acc3);
    end
  end

endmodule

// File: tb/tb_dct_t2.sv
// tb_dct_t2: directed table-driven check of dct_t2 plus reset and pipelining sequences.
// Latency: expects results two rising edges after a vector is applied.
// Backpressure: none; inputs are driven 1 time unit after each rising edge.
module tb_dct_t2;

  logic        clk;
  logic        reset;
  logic [15:0] sample0, sample1, sample2, sample3;
  logic [15:0] out_sample0, out_sample1, out_sample2, out_sample3;

  int n_tests;
  int n_fail;

  typedef struct packed {
    logic [3:0][15:0] x;
    logic [3:0][15:0] e;
  } vec_t;

  localparam int NV = 8;
  vec_t tbl[NV];

  dct_t2 dut (
    .clk         (clk),
    .reset       (reset),
    .sample0     (sample0),
    .sample1     (sample1),
    .sample2     (sample2),
    .sample3     (sample3),
    .out_sample0 (out_sample0),
    .out_sample1 (out_sample1),
    .out_sample2 (out_sample2),
    .out_sample3 (out_sample3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int x0, input int x1, input int x2, input int x3,
                              input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.x[0] = 16'(x0); v.x[1] = 16'(x1); v.x[2] = 16'(x2); v.x[3] = 16'(x3);
    v.e[0] = 16'(e0); v.e[1] = 16'(e1); v.e[2] = 16'(e2); v.e[3] = 16'(e3);
    return v;
  endfunction

  task automatic drive(input logic [3:0][15:0] x);
    sample0 = x[0];
    sample1 = x[1];
    sample2 = x[2];
    sample3 = x[3];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s X%0d: got %0d (0x%h) expected %0d (0x%h)",
               name, idx, $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic chk(input string name, input logic [3:0][15:0] e);
    chk1(name, 0, out_sample0, e[0]);
    chk1(name, 1, out_sample1, e[1]);
    chk1(name, 2, out_sample2, e[2]);
    chk1(name, 3, out_sample3, e[3]);
  endtask

  initial begin
    logic [3:0][15:0] zero;
    vec_t ramp, dc, alt;
    n_tests = 0;
    n_fail  = 0;
    zero    = '0;

    ramp = mk(3, 9, 15, 21, 24, -13, 0, -1);
    dc   = mk(1000, 1000, 1000, 1000, 2000, 0, 0, 0);
    alt  = mk(1000, -1000, 1000, -1000, 0, 765, 0, 1848);

    tbl[0] = ramp;
    tbl[1] = dc;
    tbl[2] = alt;
    tbl[3] = mk(1000, -1000, -1000, 1000, 0, 0, 2000, 0);
    tbl[4] = mk(100, 0, 0, 0, 50, 65, 50, 27);
    tbl[5] = mk(-1, 0, 0, 0, 0, -1, 0, 0);   // -0.5 rounds up to 0
`ifdef DCT_SATURATE_EN
    tbl[6] = mk(32767, 32767, 32767, 32767, 32767, 0, 0, 0);
    tbl[7] = mk(-32768, -32768, -32768, -32768, -32768, 0, 0, 0);
`else
    tbl[6] = mk(32767, 32767, 32767, 32767, -2, 0, 0, 0);
    tbl[7] = mk(-32768, -32768, -32768, -32768, 0, 0, 0, 0);
`endif

    // Reset held for two cycles with nonzero samples
    reset = 1'b1;
    drive(tbl[4].x);
    tick();
    tick();
    chk("reset_hold", zero);

    // Release reset with ramp applied: zero after 1st edge, result after 2nd
    reset = 1'b0;
    drive(ramp.x);
    tick();
    chk("post_reset_edge1", zero);
    tick();
    chk("post_reset_edge2", ramp.e);

    // Table vectors, each held for two edges
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].x);
      tick();
      tick();
      chk($sformatf("vec%0d", i), tbl[i].e);
    end

    // Back-to-back vectors: no bubble between results
    drive(ramp.x);
    tick();
    drive(dc.x);
    tick();
    chk("pipe_ramp", ramp.e);
    drive(alt.x);
    tick();
    chk("pipe_dc", dc.e);
    tick();
    chk("pipe_alt", alt.e);

    // Mid-stream reset discards in-flight vector
    drive(ramp.x);
    tick();
    reset = 1'b1;
    drive(alt.x);
    tick();
    chk("midreset_clear", zero);
    reset = 1'b0;
    drive(dc.x);
    tick();
    chk("midreset_edge1", zero);
    tick();
    chk("midreset_edge2", dc.e);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
